// File: rtl/twos_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : twos_comp_pkg
// Brief    : Shared FSM state type for the serial two's-complement scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package twos_comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin picker: first asserted request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int  NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [NREQ-1:0] w_rot;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;
    logic            w_found;

    // Rotate so that the requester at ptr lands in bit 0.
    assign w_rot = NREQ'({req, req} >> ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = IDW'(i);
            end
        end
    end

    assign w_sum     = {1'b0, ptr} + {1'b0, w_off};
    assign grant_idx = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ))
                                                 : w_sum[IDW-1:0];
    assign grant     = (en && w_found) ? (NREQ'(1) << grant_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/twos_comp_serial_sched.sv
`default_nettype none
// ============================================================================
// Module   : twos_comp_serial_sched
// Brief    : One bit-serial negation engine shared round-robin by NREQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module twos_comp_serial_sched
    import twos_comp_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    output logic [WIDTH-1:0]      res_data,
    output logic                  res_ovf,
    output logic [IDW-1:0]        res_id,
    input  logic                  res_ready,
    output logic                  busy
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_res;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_seen;
    logic               r_ovf;
    logic [IDW-1:0]     r_id;
    logic [IDW-1:0]     r_ptr;

    logic [NREQ-1:0]    w_grant;
    logic [IDW-1:0]     w_gidx;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [WIDTH-1:0]   w_operand;
    logic               w_accept;
    logic               w_b;
    logic               w_out_bit;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (r_ptr),
        .en        (r_state == ST_IDLE),
        .grant     (w_grant),
        .grant_idx (w_gidx)
    );

    assign req_ready = w_grant;
    assign w_accept  = |w_grant;
    assign w_ptr_nxt = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);

    always_comb begin
        w_operand = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == IDW'(i)) begin
                w_operand = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Copy bits up to and including the first 1, invert everything after it.
    assign w_b       = r_shreg[0];
    assign w_out_bit = r_seen ? ~w_b : w_b;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (r_cnt == c_cnt_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_seen  <= 1'b0;
            r_ovf   <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= w_operand;
                        r_id    <= w_gidx;
                        r_cnt   <= '0;
                        r_seen  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                ST_SHIFT: begin
                    r_shreg <= r_shreg >> 1;
                    r_res   <= {w_out_bit, r_res[WIDTH-1:1]};
                    r_seen  <= r_seen | w_b;
                    // Overflow only when the MSB is the first and only 1.
                    r_ovf   <= (r_cnt == c_cnt_last) ? (w_b & ~r_seen) : (r_ovf & ~w_b);
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                end
                default: ;
            endcase
        end
    end

    assign res_data = r_res;
    assign res_ovf  = r_ovf;
    assign res_id   = r_id;

endmodule
`default_nettype wire

// File: tb/tb_twos_comp_serial_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_twos_comp_serial_sched
// Brief    : Bench for the shared serial negation scheduler (WIDTH=3 and 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_twos_comp_serial_sched;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  rv3, rr3, rv8, rr8;
    logic [11:0] rd3;
    logic [31:0] rd8;
    logic        v3, o3, rdy3, busy3, v8, o8, rdy8, busy8;
    logic [2:0]  d3;
    logic [7:0]  d8;
    logic [1:0]  id3, id8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    twos_comp_serial_sched #(.WIDTH(3), .NREQ(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_data(rd3), .req_ready(rr3),
        .res_valid(v3), .res_data(d3), .res_ovf(o3), .res_id(id3),
        .res_ready(rdy3), .busy(busy3)
    );

    twos_comp_serial_sched #(.WIDTH(8), .NREQ(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv8), .req_data(rd8), .req_ready(rr8),
        .res_valid(v8), .res_data(d8), .res_ovf(o8), .res_id(id8),
        .res_ready(rdy8), .busy(busy8)
    );

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int first_at(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Behavioural model of the WIDTH=8 instance: phase 0 idle, 1 shifting, 2 result held.
    bit         known = 1'b0;
    int         ph = 0;
    int         n_left = 0;
    int         m_ptr = 0;
    logic [7:0] exp_d;
    logic       exp_o;
    int         exp_id;
    logic [3:0] acc_mask = 4'b0;
    int         grant_log[$];
    int         n_ops = 0;
    int         waitc[4];

    always @(negedge clk) begin
        int         g;
        logic [7:0] op;
        if (known) begin
            case (ph)
                0: begin
                    g = first_at(rv8, m_ptr);
                    check_eq("idle_req_ready", rr8, (g < 0) ? 32'd0 : (32'd1 << g));
                    check_eq("idle_res_valid", v8, 0);
                    check_eq("idle_busy", busy8, 0);
                end
                1: begin
                    check_eq("shift_req_ready", rr8, 0);
                    check_eq("shift_res_valid", v8, 0);
                    check_eq("shift_busy", busy8, 1);
                end
                default: begin
                    check_eq("done_req_ready", rr8, 0);
                    check_eq("done_res_valid", v8, 1);
                    check_eq("done_busy", busy8, 1);
                    check_eq("res_data", d8, exp_d);
                    check_eq("res_ovf", o8, exp_o);
                    check_eq("res_id", id8, exp_id);
                end
            endcase
        end
        acc_mask = 4'b0;
        if (!rst_n) begin
            known = 1'b1;
            ph    = 0;
            m_ptr = 0;
            for (int i = 0; i < 4; i++) waitc[i] = 0;
        end else if (known) begin
            case (ph)
                0: begin
                    g = first_at(rv8, m_ptr);
                    if (g >= 0) begin
                        op     = rd8[g*8 +: 8];
                        exp_d  = 8'(256 - int'(op));
                        exp_o  = (op == 8'h80);
                        exp_id = g;
                        m_ptr  = (g + 1) % 4;
                        check_eq("wait_bound_ok", (waitc[g] < 4) ? 1 : 0, 1);
                        waitc[g] = 0;
                        for (int i = 0; i < 4; i++) if (i != g && rv8[i]) waitc[i]++;
                        grant_log.push_back(g);
                        acc_mask[g] = 1'b1;
                        ph     = 1;
                        n_left = 8;
                    end
                end
                1: begin
                    n_left--;
                    if (n_left == 0) ph = 2;
                end
                default: begin
                    if (rdy8) begin
                        ph = 0;
                        n_ops++;
                    end
                end
            endcase
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (!busy8 && !v8) break;
        end
        check_eq("idle_reached", busy8, 0);
    endtask

    task automatic run3(input logic [2:0] op, input logic [2:0] exp);
        bit ok;
        rdy3 = 1'b1;
        @(posedge clk); #1;
        rv3[0] = 1'b1;
        rd3[2:0] = op;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rr3[0]) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("t1_grant", rr3, 1);
        @(posedge clk); #1;
        rv3 = 4'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (v3) break;
        end
        check_eq("t1_valid", v3, 1);
        check_eq("t1_data", d3, exp);
        check_eq("t1_ovf", o3, (op == 3'b100) ? 1 : 0);
        check_eq("t1_id", id3, 0);
        @(posedge clk);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h80;
            2:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    logic [2:0] t1_exp [8];
    int         t3_exp [5];
    int         base, target, cyc;

    initial begin
        t1_exp = '{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        t3_exp = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        rv3 = '0; rd3 = '0; rdy3 = 1'b0;
        rv8 = '0; rd8 = '0; rdy8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_res_valid", v8, 0);
        check_eq("rst_res_data", d8, 0);
        check_eq("rst_res_ovf", o8, 0);
        check_eq("rst_res_id", id8, 0);
        check_eq("rst_busy", busy8, 0);
        check_eq("rst_req_ready", rr8, 0);
        check_eq("rst_busy3", busy3, 0);
        rst_n = 1'b1;

        // WIDTH=3 sweep of every operand
        for (int op = 0; op < 8; op++) run3(3'(op), t1_exp[op]);

        // All requesters continuously valid: rotation from pointer 0
        @(posedge clk); #1;
        rdy8 = 1'b1;
        base = grant_log.size();
        rv8  = 4'hF;
        rd8  = $urandom;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (grant_log.size() >= base + 5) break;
        end
        rv8 = 4'b0;
        wait_idle();
        check_eq("t3_count", grant_log.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < grant_log.size()) check_eq("t3_order", grant_log[base+i], t3_exp[i]);
        end

        // Latency: requester 2, 8'h35
        rdy8 = 1'b0;
        @(posedge clk); #1;
        rv8 = 4'b0100;
        rd8[23:16] = 8'h35;
        @(posedge clk); #1;
        rv8 = 4'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("t2_valid_early", v8, 0);
        @(posedge clk); #1;
        check_eq("t2_valid", v8, 1);
        check_eq("t2_data", d8, 8'hCB);
        check_eq("t2_id", id8, 2);
        check_eq("t2_ovf", o8, 0);

        // Most-negative operand with a stalled consumer
        rdy8 = 1'b1;
        @(posedge clk); #1;
        rdy8 = 1'b0;
        rv8 = 4'b0001;
        rd8[7:0] = 8'h80;
        @(posedge clk); #1;
        rv8 = 4'b1010;
        repeat (8) @(posedge clk);
        #1;
        check_eq("t4_valid", v8, 1);
        check_eq("t4_data", d8, 8'h80);
        check_eq("t4_ovf", o8, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq("t4_hold_valid", v8, 1);
            check_eq("t4_hold_data", d8, 8'h80);
            check_eq("t4_no_ready", rr8, 0);
        end
        rv8  = 4'b0;
        rdy8 = 1'b1;
        wait_idle();

        // Reset in the middle of a shift
        @(posedge clk); #1;
        rv8 = 4'b0001;
        rd8[7:0] = 8'h5A;
        @(posedge clk); #1;
        rv8 = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_valid", v8, 0);
        check_eq("t5_busy", busy8, 0);
        check_eq("t5_data", d8, 0);
        check_eq("t5_ovf", o8, 0);
        check_eq("t5_id", id8, 0);
        check_eq("t5_ready", rr8, 0);
        rst_n = 1'b1;
        rv8 = 4'b1010;
        #1;
        check_eq("t5_first_grant", rr8, 4'b0010);
        @(posedge clk); #1;
        rv8 = 4'b0;
        wait_idle();

        // Random traffic against the model
        target = n_ops + 2000;
        cyc = 0;
        while (n_ops < target && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            rdy8 = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) rv8[i] = 1'b0;
                if (!rv8[i] && $urandom_range(0, 2) == 0) begin
                    rv8[i] = 1'b1;
                    rd8[i*8 +: 8] = pick();
                end
            end
        end
        check_eq("t6_ops_done", (n_ops >= target) ? 1 : 0, 1);
        rv8  = 4'b0;
        rdy8 = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
